// File: rtl/wide_add_seq_if.sv
// rtl/wide_add_seq_if.sv - request/result bundle for the sequential wide adder (sub exists with WIDE_ADD_SEQ_SUBTRACT_EN)
interface wide_add_seq_if #(
    parameter int SLICE_W  = 16,
    parameter int N_SLICES = 4
);
    localparam int W = SLICE_W * N_SLICES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef WIDE_ADD_SEQ_SUBTRACT_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

`ifdef WIDE_ADD_SEQ_SUBTRACT_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf, busy);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf, busy);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf, busy);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf, busy);
`endif
endinterface

// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - W-bit adder built from one time-shared SLICE_W carry-lookahead slice (WIDE_ADD_SEQ_SUBTRACT_EN adds subtract)
module wide_add_seq #(
    parameter int SLICE_W  = 16,
    parameter int N_SLICES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);
    localparam int W     = SLICE_W * N_SLICES;
    localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, beff_q;
    logic [W-1:0]       sum_q;
    logic               cout_q, ovf_q;

    logic [W-1:0]       beff_in;
    logic               cin_in;
    logic               load, step, last;

    logic [SLICE_W-1:0] a_sl, b_sl, g, p, slice_sum;
    logic [SLICE_W:0]   c;
    logic               acc, pp;

`ifdef WIDE_ADD_SEQ_SUBTRACT_EN
    // Subtraction is A + ~B + 1; the caller's cin is irrelevant then.
    assign beff_in = bus.sub ? ~bus.b : bus.b;
    assign cin_in  = bus.sub ? 1'b1 : bus.cin;
`else
    assign beff_in = bus.b;
    assign cin_in  = bus.cin;
`endif

    assign a_sl = a_q[idx_q*SLICE_W +: SLICE_W];
    assign b_sl = beff_q[idx_q*SLICE_W +: SLICE_W];
    assign g    = a_sl & b_sl;
    assign p    = a_sl ^ b_sl;

    // Each carry is the flat lookahead sum-of-products of g/p and the slice carry-in.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b1;
        c[0] = carry_q;
        for (int i = 0; i < SLICE_W; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & carry_q);
        end
    end

    assign slice_sum = p ^ c[SLICE_W-1:0];
    assign last      = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    idx_d   = '0;
                    carry_d = cin_in;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step    = 1'b1;
                carry_d = c[SLICE_W];
                if (last) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            beff_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            if (load) begin
                a_q    <= bus.a;
                beff_q <= beff_in;
            end
            if (step) begin
                sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            end
            if (step && last) begin
                cout_q <= c[SLICE_W];
                ovf_q  <= (a_q[W-1] == beff_q[W-1]) && (slice_sum[SLICE_W-1] != a_q[W-1]);
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
